// File: rtl/qspi_psram_target.sv
// qspi_psram_target: QSPI responder emulating a quad PSRAM so master-side logic can be exercised.
// Latency: pins pass 2-FF synchronisers; protocol actions land 1 clk after the detected sck edge.
// Backpressure: none; the master sets the pace and a late read word yields zeros plus rd_underrun.
// Ports: clk/reset (sync, active-low); qspi_sck/qspi_ncs/qspi_data_in from the master;
//        qspi_data_out/qspi_data_out_en to the pads; quad_mode status;
//        mem_addr/mem_rd_req/mem_rd_data/mem_rd_valid and mem_wr_data/mem_wr_valid to the backing RAM;
//        rd_underrun pulses when a read word was not ready in time.
`timescale 1ns/1ps
module qspi_psram_target #(
  parameter int ASZ     = 22,
  parameter int DSZ     = 16,
  parameter int RD_WAIT = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           qspi_sck,
  input  logic           qspi_ncs,
  input  logic [3:0]     qspi_data_in,
  output logic [3:0]     qspi_data_out,
  output logic           qspi_data_out_en,
  output logic           quad_mode,
  output logic [ASZ-1:0] mem_addr,
  output logic           mem_rd_req,
  input  logic [DSZ-1:0] mem_rd_data,
  input  logic           mem_rd_valid,
  output logic [DSZ-1:0] mem_wr_data,
  output logic           mem_wr_valid,
  output logic           rd_underrun
);

  localparam logic [7:0] WAIT_LAST = 8'(RD_WAIT);
  localparam logic [7:0] NIB_LAST  = 8'(DSZ / 4 - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;
  state_t state, state_nxt;

  // Pin synchronisers; ncs resets to deselected so nothing starts out of reset.
  logic       sck_s1, sck_s2, sck_s3;
  logic       ncs_s1, ncs_s2;
  logic [3:0] din_s1, din_s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      ncs_s1 <= 1'b1;
      ncs_s2 <= 1'b1;
      din_s1 <= 4'h0;
      din_s2 <= 4'h0;
    end else begin
      sck_s1 <= qspi_sck;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      ncs_s1 <= qspi_ncs;
      ncs_s2 <= ncs_s1;
      din_s1 <= qspi_data_in;
      din_s2 <= din_s1;
    end
  end

  // A deselect in the same clk as an sck edge suppresses the edge.
  logic rise, fall;
  assign rise = sck_s2 & ~sck_s3 & ~ncs_s2;
  assign fall = ~sck_s2 & sck_s3 & ~ncs_s2;

  // Datapath state
  logic [7:0]     cnt;
  logic [6:0]     cmd_sr;
  logic [19:0]    addr_sr;
  logic [DSZ-5:0] wr_sr;
  logic [DSZ-1:0] rd_sr;
  logic [DSZ-1:0] rd_buf;
  logic           buf_full;
  logic           is_rd;
  logic           arm_set, arm_clr;
  logic           oe;

  // Shift-in views including the nibble/bit being sampled this clk
  logic [7:0]     cmd_nxt;
  logic           cmd_last;
  logic           cmd_is_rw;
  logic [23:0]    addr_nxt;
  logic [DSZ-1:0] wr_nxt;
  logic           rd_take;
  logic           rd_have;
  logic [DSZ-1:0] rd_word;
  logic           unused_addr_bits;

  assign cmd_nxt   = quad_mode ? {cmd_sr[3:0], din_s2} : {cmd_sr, din_s2[0]};
  assign cmd_last  = quad_mode ? (cnt == 8'd1) : (cnt == 8'd7);
  assign cmd_is_rw = quad_mode && (cmd_nxt == 8'hEB || cmd_nxt == 8'h38);
  assign addr_nxt  = {addr_sr, din_s2};
  assign wr_nxt    = {wr_sr, din_s2};
  // Byte address bit 0 and bits above the word range are don't-care.
  assign unused_addr_bits = ^{addr_nxt[23:ASZ+1], addr_nxt[0]};

  // Returns are only accepted while a read burst is live; stragglers are dropped.
  assign rd_take = mem_rd_valid & ~ncs_s2 & (state == WAIT || state == RDATA);
  assign rd_have = rd_take | buf_full;
  assign rd_word = rd_take ? mem_rd_data : (buf_full ? rd_buf : '0);

  // Control strobes
  logic cmd_shift, addr_shift, addr_done, wait_tick;
  logic rd_load, rd_shift, wr_shift, wr_done;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ncs_s2) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CMD;
        CMD:     if (cmd_shift && cmd_last) state_nxt = cmd_is_rw ? ADDR : IGNORE;
        ADDR:    if (addr_done) state_nxt = is_rd ? WAIT : WDATA;
        WAIT:    if (rd_load) state_nxt = RDATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    cmd_shift  = 1'b0;
    addr_shift = 1'b0;
    addr_done  = 1'b0;
    wait_tick  = 1'b0;
    rd_load    = 1'b0;
    rd_shift   = 1'b0;
    wr_shift   = 1'b0;
    wr_done    = 1'b0;
    case (state)
      CMD:  cmd_shift = rise;
      ADDR: begin
        addr_shift = rise;
        addr_done  = rise && (cnt == 8'd5);
      end
      WAIT: begin
        wait_tick = rise;
        rd_load   = fall && (cnt == WAIT_LAST);
      end
      RDATA: begin
        rd_load  = fall && (cnt == NIB_LAST);
        rd_shift = fall && (cnt != NIB_LAST);
      end
      WDATA: begin
        wr_shift = rise;
        wr_done  = rise && (cnt == NIB_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      qspi_data_out <= 4'h0;
      oe            <= 1'b0;
      quad_mode     <= 1'b0;
      mem_addr      <= '0;
      mem_rd_req    <= 1'b0;
      mem_wr_data   <= '0;
      mem_wr_valid  <= 1'b0;
      rd_underrun   <= 1'b0;
      cnt           <= 8'd0;
      cmd_sr        <= 7'd0;
      addr_sr       <= 20'd0;
      wr_sr         <= '0;
      rd_sr         <= '0;
      rd_buf        <= '0;
      buf_full      <= 1'b0;
      is_rd         <= 1'b0;
      arm_set       <= 1'b0;
      arm_clr       <= 1'b0;
    end else begin
      mem_rd_req   <= 1'b0;
      mem_wr_valid <= 1'b0;
      rd_underrun  <= 1'b0;

      // Post-write increment: the strobe cycle shows the word's own address.
      if (mem_wr_valid) mem_addr <= mem_addr + ASZ'(1);

      if (rd_take) begin
        rd_buf   <= mem_rd_data;
        buf_full <= 1'b1;
      end

      // Deselect: quad-mode changes armed during the command commit here.
      if (ncs_s2) begin
        oe       <= 1'b0;
        buf_full <= 1'b0;
        arm_set  <= 1'b0;
        arm_clr  <= 1'b0;
        if (arm_set)      quad_mode <= 1'b1;
        else if (arm_clr) quad_mode <= 1'b0;
      end

      if (state == IDLE) cnt <= 8'd0;

      if (cmd_shift) begin
        cmd_sr <= cmd_nxt[6:0];
        cnt    <= cnt + 8'd1;
        if (cmd_last) begin
          cnt   <= 8'd0;
          is_rd <= (cmd_nxt == 8'hEB);
          if (!quad_mode && cmd_nxt == 8'h35) arm_set <= 1'b1;
          if (quad_mode && cmd_nxt == 8'hF5)  arm_clr <= 1'b1;
        end
      end

      if (addr_shift) begin
        addr_sr <= addr_nxt[19:0];
        cnt     <= cnt + 8'd1;
        if (addr_done) begin
          cnt        <= 8'd0;
          mem_addr   <= addr_nxt[ASZ:1];
          mem_rd_req <= is_rd;
        end
      end

      if (wait_tick) cnt <= cnt + 8'd1;

      // Word boundary: drive the first nibble and prefetch the following word.
      if (rd_load) begin
        rd_sr         <= rd_word << 4;
        qspi_data_out <= rd_word[DSZ-1 -: 4];
        oe            <= 1'b1;
        buf_full      <= 1'b0;
        rd_underrun   <= ~rd_have;
        mem_addr      <= mem_addr + ASZ'(1);
        mem_rd_req    <= 1'b1;
        cnt           <= 8'd0;
      end

      if (rd_shift) begin
        qspi_data_out <= rd_sr[DSZ-1 -: 4];
        rd_sr         <= rd_sr << 4;
        cnt           <= cnt + 8'd1;
      end

      if (wr_shift) begin
        wr_sr <= wr_nxt[DSZ-5:0];
        cnt   <= cnt + 8'd1;
        if (wr_done) begin
          cnt          <= 8'd0;
          mem_wr_data  <= wr_nxt;
          mem_wr_valid <= 1'b1;
        end
      end
    end
  end

  // Gated by the synchronised select so the pad never drives while deselected.
  assign qspi_data_out_en = oe & ~ncs_s2;

endmodule

// File: tb/tb_qspi_psram_target.sv
`timescale 1ns/1ps
module tb_qspi_psram_target;

  logic        clk = 1'b0;
  logic        reset;
  logic        qspi_sck;
  logic        qspi_ncs;
  logic [3:0]  qspi_data_in;
  logic [3:0]  qspi_data_out;
  logic        qspi_data_out_en;
  logic        quad_mode;
  logic [21:0] mem_addr;
  logic        mem_rd_req;
  logic [15:0] mem_rd_data = 16'h0;
  logic        mem_rd_valid = 1'b0;
  logic [15:0] mem_wr_data;
  logic        mem_wr_valid;
  logic        rd_underrun;

  int tests_run = 0;
  int tests_failed = 0;

  qspi_psram_target #(.ASZ(22), .DSZ(16), .RD_WAIT(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .qspi_sck         (qspi_sck),
    .qspi_ncs         (qspi_ncs),
    .qspi_data_in     (qspi_data_in),
    .qspi_data_out    (qspi_data_out),
    .qspi_data_out_en (qspi_data_out_en),
    .quad_mode        (quad_mode),
    .mem_addr         (mem_addr),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_data      (mem_rd_data),
    .mem_rd_valid     (mem_rd_valid),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_valid     (mem_wr_valid),
    .rd_underrun      (rd_underrun)
  );

  always #5 clk = ~clk;

  // Strobe logs
  logic [21:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [21:0] rd_addr_q[$];
  int          under_cnt = 0;

  always @(negedge clk) begin
    if (mem_wr_valid) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wr_data);
    end
    if (mem_rd_req) rd_addr_q.push_back(mem_addr);
    if (rd_underrun) under_cnt++;
  end

  // Backing RAM: answers a request two clocks later from a sparse table.
  logic [15:0] ram_mem [logic [21:0]];
  logic        ram_en = 1'b0;
  int          lat_cnt = 0;
  logic [21:0] pend_addr = '0;

  always @(negedge clk) begin
    mem_rd_valid = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        mem_rd_valid = 1'b1;
        if (ram_mem.exists(pend_addr)) mem_rd_data = ram_mem[pend_addr];
        else mem_rd_data = 16'h0000;
      end
    end
    if (mem_rd_req && ram_en) begin
      lat_cnt   = 2;
      pend_addr = mem_addr;
    end
  end

  // Bus-level helpers (no checking)
  task automatic pulse(input logic [3:0] d);
    qspi_data_in = d;
    #50;
    qspi_sck = 1'b1;
    #50;
    qspi_sck = 1'b0;
  endtask

  task automatic sck_pulse(input logic [3:0] d, output logic [3:0] q);
    qspi_data_in = d;
    #50;
    q = qspi_data_out;
    qspi_sck = 1'b1;
    #50;
    qspi_sck = 1'b0;
  endtask

  task automatic cs_low();
    qspi_ncs = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #50;
    qspi_ncs = 1'b1;
    #200;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]});
  endtask

  task automatic quad_byte(input logic [7:0] b);
    pulse(b[7:4]);
    pulse(b[3:0]);
  endtask

  task automatic quad_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
  endtask

  task automatic dummy6();
    for (int i = 0; i < 6; i++) pulse(4'h0);
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b0;
    qspi_sck = 1'b0;
    qspi_ncs = 1'b1;
    qspi_data_in = 4'h0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #20;
    tests_run++; if (qspi_data_out !== 4'h0) begin tests_failed++; $display("FAIL reset_data_out got %h want 0", qspi_data_out); end
    tests_run++; if (qspi_data_out_en !== 1'b0) begin tests_failed++; $display("FAIL reset_data_out_en got %b want 0", qspi_data_out_en); end
    tests_run++; if (quad_mode !== 1'b0) begin tests_failed++; $display("FAIL reset_quad_mode got %b want 0", quad_mode); end
    tests_run++; if (mem_addr !== 22'h0) begin tests_failed++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    tests_run++; if (mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rd_req got %b want 0", mem_rd_req); end
    tests_run++; if (mem_wr_data !== 16'h0) begin tests_failed++; $display("FAIL reset_mem_wr_data got %h want 0", mem_wr_data); end
    tests_run++; if (mem_wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_wr_valid got %b want 0", mem_wr_valid); end
    tests_run++; if (rd_underrun !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_underrun got %b want 0", rd_underrun); end
  endtask

  task automatic test_enter_quad();
    int wb, rb;
    wb = wr_addr_q.size();
    rb = rd_addr_q.size();
    cs_low();
    spi_byte(8'h35);
    #100;
    tests_run++; if (quad_mode !== 1'b0) begin tests_failed++; $display("FAIL enter_quad_before_ncs got %b want 0", quad_mode); end
    cs_high();
    tests_run++; if (quad_mode !== 1'b1) begin tests_failed++; $display("FAIL enter_quad_after_ncs got %b want 1", quad_mode); end
    tests_run++; if (wr_addr_q.size() != wb) begin tests_failed++; $display("FAIL enter_quad_wr_strobes got %0d want 0", wr_addr_q.size() - wb); end
    tests_run++; if (rd_addr_q.size() != rb) begin tests_failed++; $display("FAIL enter_quad_rd_strobes got %0d want 0", rd_addr_q.size() - rb); end
  endtask

  task automatic test_quad_write();
    int wb, rb;
    wb = wr_addr_q.size();
    rb = rd_addr_q.size();
    cs_low();
    quad_byte(8'h38);
    quad_addr(24'h000010);
    quad_byte(8'hBE); quad_byte(8'hEF);
    quad_byte(8'h12); quad_byte(8'h34);
    cs_high();
    tests_run++;
    if (wr_addr_q.size() - wb != 2) begin
      tests_failed++; $display("FAIL write_count got %0d want 2", wr_addr_q.size() - wb);
    end else begin
      tests_run++; if (wr_addr_q[wb] !== 22'h8) begin tests_failed++; $display("FAIL write0_addr got %h want 8", wr_addr_q[wb]); end
      tests_run++; if (wr_data_q[wb] !== 16'hBEEF) begin tests_failed++; $display("FAIL write0_data got %h want beef", wr_data_q[wb]); end
      tests_run++; if (wr_addr_q[wb+1] !== 22'h9) begin tests_failed++; $display("FAIL write1_addr got %h want 9", wr_addr_q[wb+1]); end
      tests_run++; if (wr_data_q[wb+1] !== 16'h1234) begin tests_failed++; $display("FAIL write1_data got %h want 1234", wr_data_q[wb+1]); end
    end
    tests_run++; if (mem_addr !== 22'hA) begin tests_failed++; $display("FAIL write_addr_after got %h want a", mem_addr); end
    tests_run++; if (rd_addr_q.size() != rb) begin tests_failed++; $display("FAIL write_rd_strobes got %0d want 0", rd_addr_q.size() - rb); end
  endtask

  task automatic test_quad_read();
    int rb, ub;
    logic [3:0]  q;
    logic [31:0] exp_v;
    exp_v = 32'hA5C30F0F;
    ram_mem[22'h10] = 16'hA5C3;
    ram_mem[22'h11] = 16'h0F0F;
    ram_en = 1'b1;
    rb = rd_addr_q.size();
    ub = under_cnt;
    cs_low();
    quad_byte(8'hEB);
    quad_addr(24'h000020);
    for (int i = 0; i < 5; i++) pulse(4'h0);
    qspi_data_in = 4'h0;
    #50;
    qspi_sck = 1'b1;
    #50;
    tests_run++; if (qspi_data_out_en !== 1'b0) begin tests_failed++; $display("FAIL read_oe_before_fall got %b want 0", qspi_data_out_en); end
    qspi_sck = 1'b0;
    #40;
    tests_run++; if (qspi_data_out_en !== 1'b1) begin tests_failed++; $display("FAIL read_oe_after_fall got %b want 1", qspi_data_out_en); end
    #10;
    for (int i = 0; i < 8; i++) begin
      sck_pulse(4'h0, q);
      tests_run++;
      if (q !== exp_v[31-4*i -: 4]) begin
        tests_failed++; $display("FAIL read_nibble%0d got %h want %h", i, q, exp_v[31-4*i -: 4]);
      end
    end
    cs_high();
    tests_run++; if (qspi_data_out_en !== 1'b0) begin tests_failed++; $display("FAIL read_oe_after_ncs got %b want 0", qspi_data_out_en); end
    tests_run++; if (under_cnt != ub) begin tests_failed++; $display("FAIL read_underruns got %0d want 0", under_cnt - ub); end
    tests_run++;
    if (rd_addr_q.size() - rb < 2) begin
      tests_failed++; $display("FAIL read_req_count got %0d want >=2", rd_addr_q.size() - rb);
    end else begin
      tests_run++; if (rd_addr_q[rb] !== 22'h10) begin tests_failed++; $display("FAIL read_req0_addr got %h want 10", rd_addr_q[rb]); end
      tests_run++; if (rd_addr_q[rb+1] !== 22'h11) begin tests_failed++; $display("FAIL read_req1_addr got %h want 11", rd_addr_q[rb+1]); end
    end
  endtask

  task automatic test_underrun();
    int ub;
    logic [3:0] q;
    ram_en = 1'b0;
    ub = under_cnt;
    cs_low();
    quad_byte(8'hEB);
    quad_addr(24'h000040);
    dummy6();
    for (int i = 0; i < 8; i++) begin
      sck_pulse(4'h0, q);
      tests_run++; if (q !== 4'h0) begin tests_failed++; $display("FAIL underrun_nibble%0d got %h want 0", i, q); end
    end
    cs_high();
    // loads: end of wait, after nibble 4, after nibble 8
    tests_run++; if (under_cnt - ub != 3) begin tests_failed++; $display("FAIL underrun_pulses got %0d want 3", under_cnt - ub); end
    ram_en = 1'b1;
  endtask

  task automatic test_partial_write();
    int wb;
    wb = wr_addr_q.size();
    cs_low();
    quad_byte(8'h38);
    quad_addr(24'h000100);
    pulse(4'hC);
    pulse(4'h0);
    cs_high();
    tests_run++; if (wr_addr_q.size() != wb) begin tests_failed++; $display("FAIL partial_no_strobe got %0d want 0", wr_addr_q.size() - wb); end
    tests_run++; if (qspi_data_out_en !== 1'b0) begin tests_failed++; $display("FAIL partial_oe got %b want 0", qspi_data_out_en); end
    cs_low();
    quad_byte(8'h38);
    quad_addr(24'h000100);
    quad_byte(8'hC0); quad_byte(8'hDE);
    cs_high();
    tests_run++;
    if (wr_addr_q.size() - wb != 1) begin
      tests_failed++; $display("FAIL partial_next_count got %0d want 1", wr_addr_q.size() - wb);
    end else begin
      tests_run++; if (wr_addr_q[wb] !== 22'h80) begin tests_failed++; $display("FAIL partial_next_addr got %h want 80", wr_addr_q[wb]); end
      tests_run++; if (wr_data_q[wb] !== 16'hC0DE) begin tests_failed++; $display("FAIL partial_next_data got %h want c0de", wr_data_q[wb]); end
    end
  endtask

  task automatic test_addr_wrap();
    int rb;
    logic [3:0] q;
    ram_mem[22'h3FFFFF] = 16'h1111;
    ram_mem[22'h000000] = 16'h2222;
    rb = rd_addr_q.size();
    cs_low();
    quad_byte(8'hEB);
    quad_addr(24'h7FFFFE);
    dummy6();
    for (int i = 0; i < 4; i++) begin
      sck_pulse(4'h0, q);
      tests_run++; if (q !== 4'h1) begin tests_failed++; $display("FAIL wrap_nibble%0d got %h want 1", i, q); end
    end
    cs_high();
    tests_run++;
    if (rd_addr_q.size() - rb < 2) begin
      tests_failed++; $display("FAIL wrap_req_count got %0d want >=2", rd_addr_q.size() - rb);
    end else begin
      tests_run++; if (rd_addr_q[rb] !== 22'h3FFFFF) begin tests_failed++; $display("FAIL wrap_req0_addr got %h want 3fffff", rd_addr_q[rb]); end
      tests_run++; if (rd_addr_q[rb+1] !== 22'h000000) begin tests_failed++; $display("FAIL wrap_req1_addr got %h want 0", rd_addr_q[rb+1]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int wb;
    logic [3:0] q;
    wb = wr_addr_q.size();
    cs_low();
    quad_byte(8'hEB);
    quad_addr(24'h000000);
    dummy6();
    for (int i = 0; i < 2; i++) begin
      sck_pulse(4'h0, q);
      tests_run++; if (q !== 4'h2) begin tests_failed++; $display("FAIL midrst_nibble%0d got %h want 2", i, q); end
    end
    #30;
    tests_run++; if (qspi_data_out_en !== 1'b1) begin tests_failed++; $display("FAIL midrst_oe_before got %b want 1", qspi_data_out_en); end
    reset = 1'b0;
    #10;
    tests_run++; if (qspi_data_out !== 4'h0) begin tests_failed++; $display("FAIL midrst_data_out got %h want 0", qspi_data_out); end
    tests_run++; if (qspi_data_out_en !== 1'b0) begin tests_failed++; $display("FAIL midrst_oe got %b want 0", qspi_data_out_en); end
    tests_run++; if (quad_mode !== 1'b0) begin tests_failed++; $display("FAIL midrst_quad_mode got %b want 0", quad_mode); end
    tests_run++; if (mem_addr !== 22'h0) begin tests_failed++; $display("FAIL midrst_mem_addr got %h want 0", mem_addr); end
    tests_run++; if (mem_rd_req !== 1'b0) begin tests_failed++; $display("FAIL midrst_rd_req got %b want 0", mem_rd_req); end
    tests_run++; if (mem_wr_data !== 16'h0) begin tests_failed++; $display("FAIL midrst_wr_data got %h want 0", mem_wr_data); end
    tests_run++; if (mem_wr_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_wr_valid got %b want 0", mem_wr_valid); end
    tests_run++; if (rd_underrun !== 1'b0) begin tests_failed++; $display("FAIL midrst_underrun got %b want 0", rd_underrun); end
    qspi_ncs = 1'b1;
    #20;
    reset = 1'b1;
    #100;
    tests_run++; if (wr_addr_q.size() != wb) begin tests_failed++; $display("FAIL midrst_wr_strobes got %0d want 0", wr_addr_q.size() - wb); end
  endtask

  initial begin
    test_reset();
    test_enter_quad();
    test_quad_write();
    test_quad_read();
    test_underrun();
    test_partial_write();
    test_addr_wrap();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qspi_psram_target.md
Name: qspi_psram_target

Overview:
- QSPI target (responder) that emulates the PSRAM seen by our QSPI master, so that master-side logic can be exercised in-fabric and on the bench.
- Oversamples qspi_sck/qspi_ncs/qspi_data_in on the system clock.
- Decodes 0x35 (enter quad), 0xF5 (exit quad), 0xEB (quad read) and 0x38 (quad write).
- Exposes a word-wide memory-side request/strobe interface to a backing RAM.

Parameters:
ASZ, 22, word address width on the memory side
DSZ, 16, data word width; must be a multiple of 4
RD_WAIT, 6, quad-read dummy sck cycles between the last address nibble and the first data nibble

Ports:
clk  input  1  system clock; must be at least 4x qspi_sck frequency
reset  input  1  synchronous reset, active-low (asserted when 0)
qspi_sck  input  1  QSPI serial clock from master (asynchronous to clk)
qspi_ncs  input  1  chip select, active low
qspi_data_in  input  4  IO[3:0] from master
qspi_data_out  output  4  IO[3:0] driven to master
qspi_data_out_en  output  1  pad output enable
quad_mode  output  1  1 = quad mode active
mem_addr  output  ASZ  current word address
mem_rd_req  output  1  one-clk pulse: fetch word at mem_addr
mem_rd_data  input  DSZ  read word
mem_rd_valid  input  1  mem_rd_data valid (one clk)
mem_wr_data  output  DSZ  assembled write word
mem_wr_valid  output  1  one-clk pulse: write mem_wr_data at mem_addr
rd_underrun  output  1  one-clk pulse: read word not available when needed

Behaviour:
- Input synchronisation:
  - qspi_sck, qspi_ncs and qspi_data_in pass through 2-FF synchronisers, plus one history stage on sck.
  - rise/fall = edge detect on synchronised sck.
  - All protocol events occur on the clk following the detected edge; data sampled on rise, outputs updated on fall.
- Reset values: qspi_data_out=0, qspi_data_out_en=0, quad_mode=0, mem_addr=0, mem_rd_req=0, mem_wr_data=0, mem_wr_valid=0, rd_underrun=0. FSM=IDLE.
- Reset takes effect even mid-transaction: output enable drops the next clk, and no strobe is issued.
- FSM states: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
  - IDLE -> CMD when synchronised ncs is low; clear bit/nibble counters.
- CMD state:
  - SPI mode (quad_mode=0): shift io[0] MSB-first, 8 rises.
  - Quad mode: shift 4 bits/rise, 2 rises.
  - Quad mode: 0xEB or 0x38 -> ADDR; 0xF5 -> arm quad_mode clear.
  - SPI mode: 0x35 -> arm quad_mode set.
  - Anything else -> IGNORE.
  - An armed quad-mode change takes effect on the ncs rising edge, not before.
- ADDR: 6 quad rises collect 24-bit byte address, MSB nibble first.
  - mem_addr = addr24[ASZ:1]; bits above ASZ and bit 0 are ignored.
  - After the 6th rise: read -> WAIT, with mem_rd_req pulsed once; write -> WDATA.
- WAIT: count RD_WAIT rises; the master drives no data.
  - On the fall after the last wait rise: load the shift register from the prefetch buffer, drive its MSB nibble, set qspi_data_out_en=1, go RDATA.
- RDATA:
  - Each fall shifts the next nibble out, MSB first; DSZ/4 nibbles per word.
  - When the first nibble of a word is driven: mem_addr += 1 (mod 2^ASZ) and pulse mem_rd_req to prefetch the next word.
  - mem_rd_valid captures mem_rd_data into the prefetch buffer and sets buffer-full; the buffer is cleared on load.
  - Load with buffer empty -> load all zeros and pulse rd_underrun.
- WDATA:
  - Each rise shifts a nibble in.
  - On every DSZ/4-th nibble: mem_wr_data = assembled word, pulse mem_wr_valid with mem_addr holding that word's address, then mem_addr += 1 on the following clk.
- IGNORE: no outputs change until ncs goes high.
- ncs high (synchronised) in any state:
  - qspi_data_out_en=0 the same clk; FSM -> IDLE.
  - A partial write word is discarded; no mem_wr_valid.
  - An outstanding read may still return and is dropped.
- Simultaneous events:
  - An ncs rise in the same clk as a sck edge: ncs wins, and the edge is ignored.
  - mem_rd_valid in the same clk as a buffer load: the load takes the new data, with no underrun.
- Counters wrap only via mem_addr.
- qspi_data_out_en is never 1 while ncs is high.

Test Plan:
- After reset, SPI-clock 0x35 on io[0] (8 sck), raise ncs -> quad_mode=1 only after ncs rise; no mem strobes.
- Quad write: cmd 0x38, addr 0x000010, data 0xBEEF,0x1234 -> mem_wr_valid twice:
  - first at mem_addr=0x8 with data 0xBEEF;
  - second at mem_addr=0x9 with data 0x1234.
- Quad read: cmd 0xEB, addr 0x000020, 6 dummy; RAM returns 0xA5C3 then 0x0F0F with 2-clk latency:
  - io nibbles are A,5,C,3,0,F,0,F;
  - mem_rd_req at addr 0x10 then 0x11;
  - qspi_data_out_en rises exactly on the fall after the 6th dummy rise.
- Read with RAM never asserting mem_rd_valid -> first word nibbles all 0, and rd_underrun pulses once per word loaded.
- ncs raised after 2 nibbles of a write word -> no mem_wr_valid, FSM IDLE; the next transaction decodes correctly.
- Word address 0x3FFFFF, read 2 words -> second mem_rd_req at mem_addr=0x000000.
- reset=0 asserted mid-RDATA -> all outputs return to reset values the next clk; quad_mode=0.
